// File: rtl/manchester_rx_deframer_pkg.sv
// Shared definitions for the Manchester receive deframer: FSM encoding,
// error codes and the default sync byte.
package manchester_pkg;

    typedef enum logic [1:0] {
        S_HUNT    = 2'd0,
        S_LEN     = 2'd1,
        S_PAYLOAD = 2'd2,
        S_CHK     = 2'd3
    } state_e;

    localparam logic [2:0] ERR_NONE = 3'd0;
    localparam logic [2:0] ERR_LEN  = 3'd1;
    localparam logic [2:0] ERR_OVF  = 3'd2;
    localparam logic [2:0] ERR_CHK  = 3'd3;
    localparam logic [2:0] ERR_TMO  = 3'd4;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hD5;

    // Running XOR checksum step over one received byte.
    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/manchester_rx_deframer_if.sv
// AXI-Stream byte channel carrying committed frame payload out of the deframer.
interface manchester_rx_deframer_if;

    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/manchester_rx_deframer_fifo.sv
// Frame FIFO with speculative write pointer: bytes become readable only after
// commit, and rollback discards everything written since the last commit.
module deframer_fifo
    import manchester_pkg::*;
#(
    parameter int FIFO_AW = 7
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 i_wr_en,
    input  logic [8:0]           i_wr_data,
    input  logic                 i_commit,
    input  logic                 i_rollback,
    output logic [FIFO_AW:0]     o_free,
    manchester_rx_deframer_if.master m_axis
);

    localparam int DEPTH = 1 << FIFO_AW;

    logic [8:0]         r_mem [DEPTH];
    logic [FIFO_AW:0]   r_wr_ptr;
    logic [FIFO_AW:0]   r_commit_ptr;
    logic [FIFO_AW:0]   r_rd_ptr;

    logic [FIFO_AW:0]   w_wr_ptr_nxt;
    logic               w_tvalid;
    logic               w_rd_fire;
    logic [8:0]         w_rd_word;

    // Commit captures the pointer including a write in the same cycle.
    assign w_wr_ptr_nxt = r_wr_ptr + {{FIFO_AW{1'b0}}, i_wr_en};
    assign w_tvalid     = (r_rd_ptr != r_commit_ptr);
    assign w_rd_fire    = w_tvalid & m_axis.tready;
    assign w_rd_word    = r_mem[r_rd_ptr[FIFO_AW-1:0]];

    assign o_free        = {1'b1, {FIFO_AW{1'b0}}} - (r_commit_ptr - r_rd_ptr);
    assign m_axis.tvalid = w_tvalid;
    assign m_axis.tdata  = w_tvalid ? w_rd_word[7:0] : 8'h00;
    assign m_axis.tlast  = w_tvalid ? w_rd_word[8]   : 1'b0;

    // Payload storage write port.
    always_ff @(posedge aclk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr[FIFO_AW-1:0]] <= i_wr_data;
        end
    end

    // Write, commit and read pointer update.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_rd_ptr     <= '0;
        end else begin
            if (i_rollback) begin
                r_wr_ptr <= r_commit_ptr;
            end else begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (i_commit) begin
                r_commit_ptr <= w_wr_ptr_nxt;
            end
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + {{FIFO_AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/manchester_rx_deframer.sv
// Sync hunt, length-prefixed frame parse and commit/rollback into the frame FIFO.
// Optional trailing XOR checksum byte is enabled by MANCH_DEFRAMER_CHK_EN.
module manchester_rx_deframer
    import manchester_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int          MAX_LEN   = 64,
    parameter int          FIFO_AW   = 7,
    parameter int          TIMEOUT   = 2000
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [7:0]  s_byte_data,
    input  logic        s_byte_valid,
    manchester_rx_deframer_if.master m_axis,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [2:0]  err_code
);

    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] ST_HUNT    = S_HUNT;
    localparam logic [1:0] ST_LEN     = S_LEN;
    localparam logic [1:0] ST_PAYLOAD = S_PAYLOAD;
`ifdef MANCH_DEFRAMER_CHK_EN
    localparam logic [1:0] ST_CHK     = S_CHK;
    logic [7:0]            r_csum;
`endif

    logic [1:0]       r_state;
    logic [7:0]       r_remain;
    logic [TW-1:0]    r_tmo_cnt;
    logic             r_frame_ok;
    logic             r_frame_err;
    logic [2:0]       r_err_code;

    logic [1:0]       w_state_nxt;
    logic             w_wr_en;
    logic             w_commit;
    logic             w_fail;
    logic [2:0]       w_fail_code;
    logic             w_tmo;
    logic             w_last;
    logic [FIFO_AW:0] w_free;

    // A byte in the same cycle as the expiry keeps the frame alive.
    assign w_tmo  = (r_state != ST_HUNT) && !s_byte_valid && (r_tmo_cnt == TMO_LAST);
    assign w_last = (r_remain == 8'd1);

    deframer_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .aclk       (aclk),
        .areset     (areset),
        .i_wr_en    (w_wr_en),
        .i_wr_data  ({w_last, s_byte_data}),
        .i_commit   (w_commit),
        .i_rollback (w_fail),
        .o_free     (w_free),
        .m_axis     (m_axis)
    );

    // Frame FSM next-state and FIFO control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_commit    = 1'b0;
        w_fail      = 1'b0;
        w_fail_code = ERR_NONE;
        case (r_state)
            ST_HUNT: begin
                if (s_byte_valid && (s_byte_data == SYNC_BYTE)) begin
                    w_state_nxt = ST_LEN;
                end else begin
                    w_state_nxt = ST_HUNT;
                end
            end
            ST_LEN: begin
                if (s_byte_valid) begin
                    if ((s_byte_data == 8'd0) || (32'(s_byte_data) > MAX_LEN)) begin
                        w_fail      = 1'b1;
                        w_fail_code = ERR_LEN;
                        w_state_nxt = ST_HUNT;
                    end else if (32'(s_byte_data) > 32'(w_free)) begin
                        w_fail      = 1'b1;
                        w_fail_code = ERR_OVF;
                        w_state_nxt = ST_HUNT;
                    end else begin
                        w_state_nxt = ST_PAYLOAD;
                    end
                end else if (w_tmo) begin
                    w_fail      = 1'b1;
                    w_fail_code = ERR_TMO;
                    w_state_nxt = ST_HUNT;
                end else begin
                    w_state_nxt = ST_LEN;
                end
            end
            ST_PAYLOAD: begin
                if (s_byte_valid) begin
                    w_wr_en = 1'b1;
                    if (w_last) begin
`ifdef MANCH_DEFRAMER_CHK_EN
                        w_state_nxt = ST_CHK;
`else
                        w_commit    = 1'b1;
                        w_state_nxt = ST_HUNT;
`endif
                    end else begin
                        w_state_nxt = ST_PAYLOAD;
                    end
                end else if (w_tmo) begin
                    w_fail      = 1'b1;
                    w_fail_code = ERR_TMO;
                    w_state_nxt = ST_HUNT;
                end else begin
                    w_state_nxt = ST_PAYLOAD;
                end
            end
`ifdef MANCH_DEFRAMER_CHK_EN
            ST_CHK: begin
                if (s_byte_valid) begin
                    if (s_byte_data == r_csum) begin
                        w_commit = 1'b1;
                    end else begin
                        w_fail      = 1'b1;
                        w_fail_code = ERR_CHK;
                    end
                    w_state_nxt = ST_HUNT;
                end else if (w_tmo) begin
                    w_fail      = 1'b1;
                    w_fail_code = ERR_TMO;
                    w_state_nxt = ST_HUNT;
                end else begin
                    w_state_nxt = ST_CHK;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_HUNT;
            end
        endcase
    end

    // FSM state, remaining-length and inter-byte timeout counters.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state   <= ST_HUNT;
            r_remain  <= 8'd0;
            r_tmo_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (s_byte_valid && (r_state == ST_LEN)) begin
                r_remain <= s_byte_data;
            end else if (s_byte_valid && (r_state == ST_PAYLOAD)) begin
                r_remain <= r_remain - 8'd1;
            end
            if ((r_state == ST_HUNT) || s_byte_valid) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + TW'(1);
            end
        end
    end

`ifdef MANCH_DEFRAMER_CHK_EN
    // Checksum seeded with the length byte, folded over the payload.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_csum <= 8'd0;
        end else if (s_byte_valid && (r_state == ST_LEN)) begin
            r_csum <= s_byte_data;
        end else if (s_byte_valid && (r_state == ST_PAYLOAD)) begin
            r_csum <= csum_step(r_csum, s_byte_data);
        end
    end
`endif

    // Status pulses and sticky error code.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_frame_ok  <= w_commit;
            r_frame_err <= w_fail;
            if (w_fail) begin
                r_err_code <= w_fail_code;
            end
        end
    end

    assign frame_ok  = r_frame_ok;
    assign frame_err = r_frame_err;
    assign err_code  = r_err_code;

endmodule

// File: tb/tb_manchester_rx_deframer.sv
// Directed bench for manchester_rx_deframer; adapts to MANCH_DEFRAMER_CHK_EN.
module tb_manchester_rx_deframer;

    logic       aclk = 1'b0;
    logic       areset;
    logic [7:0] s_byte_data;
    logic       s_byte_valid;
    logic       frame_ok;
    logic       frame_err;
    logic [2:0] err_code;

    manchester_rx_deframer_if m_axis();

    manchester_rx_deframer #(
        .SYNC_BYTE (8'hD5),
        .MAX_LEN   (64),
        .FIFO_AW   (7),
        .TIMEOUT   (2000)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .s_byte_data  (s_byte_data),
        .s_byte_valid (s_byte_valid),
        .m_axis       (m_axis),
        .frame_ok     (frame_ok),
        .frame_err    (frame_err),
        .err_code     (err_code)
    );

    always #5 aclk = ~aclk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] pl_q[$];
    logic [8:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the strobe is sampled on the following posedge.
    task automatic send_byte(input logic [7:0] b);
        s_byte_data  = b;
        s_byte_valid = 1'b1;
        @(negedge aclk);
        s_byte_valid = 1'b0;
        s_byte_data  = 8'h00;
    endtask

    task automatic fill(input int len, input logic [7:0] seed);
        pl_q.delete();
        for (int i = 0; i < len; i++) begin
            pl_q.push_back(seed + 8'(i));
        end
    endtask

    task automatic expect_payload();
        for (int i = 0; i < pl_q.size(); i++) begin
            exp_q.push_back({(i == pl_q.size() - 1), pl_q[i]});
        end
    endtask

    task automatic send_frame(input logic corrupt);
        logic [7:0] cs;
        cs = 8'(pl_q.size());
        send_byte(8'hD5);
        send_byte(8'(pl_q.size()));
        for (int i = 0; i < pl_q.size(); i++) begin
            cs = cs ^ pl_q[i];
            send_byte(pl_q[i]);
        end
`ifdef MANCH_DEFRAMER_CHK_EN
        send_byte(corrupt ? ~cs : cs);
`else
        if (corrupt) begin
            $display("[TB] corrupt checksum requested without checksum build");
        end
`endif
    endtask

    task automatic drain(input int n, input string tag);
        logic [8:0] e;
        m_axis.tready = 1'b1;
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            check({tag, "_tvalid"}, 32'(m_axis.tvalid), 32'd1);
            check({tag, "_word"}, 32'({m_axis.tlast, m_axis.tdata}), 32'(e));
            @(negedge aclk);
        end
        check({tag, "_empty"}, 32'(m_axis.tvalid), 32'd0);
        m_axis.tready = 1'b0;
    endtask

    initial begin
        areset        = 1'b1;
        s_byte_data   = 8'h00;
        s_byte_valid  = 1'b0;
        m_axis.tready = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        check("rst_tvalid", 32'(m_axis.tvalid), 32'd0);
        check("rst_tdata",  32'(m_axis.tdata),  32'd0);
        check("rst_tlast",  32'(m_axis.tlast),  32'd0);
        check("rst_ok",     32'(frame_ok),      32'd0);
        check("rst_err",    32'(frame_err),     32'd0);
        check("rst_code",   32'(err_code),      32'd0);
        areset = 1'b0;
        @(negedge aclk);

        // Basic frame 11,22,33 with tready already high.
        m_axis.tready = 1'b1;
        pl_q = '{8'h11, 8'h22, 8'h33};
        expect_payload();
        send_frame(1'b0);
        check("f1_ok",   32'(frame_ok), 32'd1);
        check("f1_code", 32'(err_code), 32'd0);
        drain(3, "f1");
        check("f1_ok_pulse", 32'(frame_ok), 32'd0);

`ifdef MANCH_DEFRAMER_CHK_EN
        pl_q = '{8'h11, 8'h22, 8'h33};
        send_frame(1'b1);
        check("chk_err",    32'(frame_err),     32'd1);
        check("chk_code",   32'(err_code),      32'd3);
        check("chk_hidden", 32'(m_axis.tvalid), 32'd0);
        fill(4, 8'h21);
        expect_payload();
        send_frame(1'b0);
        check("chk_next_ok", 32'(frame_ok), 32'd1);
        drain(4, "chk_next");
`endif

        // Illegal lengths, then a frame must still decode.
        send_byte(8'hD5);
        send_byte(8'h00);
        check("len0_err",  32'(frame_err), 32'd1);
        check("len0_code", 32'(err_code),  32'd1);
        send_byte(8'hD5);
        send_byte(8'h41);
        check("len65_err",  32'(frame_err), 32'd1);
        check("len65_code", 32'(err_code),  32'd1);
        check("len65_hidden", 32'(m_axis.tvalid), 32'd0);
        pl_q = '{8'h5A, 8'hD5};
        expect_payload();
        send_frame(1'b0);
        check("len_next_ok", 32'(frame_ok), 32'd1);
        drain(2, "len_next");

        // Two full 64-byte frames fill the FIFO; a third is refused.
        m_axis.tready = 1'b0;
        fill(64, 8'h01);
        expect_payload();
        send_frame(1'b0);
        check("ovf_f1_ok", 32'(frame_ok), 32'd1);
        fill(64, 8'h80);
        expect_payload();
        send_frame(1'b0);
        check("ovf_f2_ok", 32'(frame_ok), 32'd1);
        send_byte(8'hD5);
        send_byte(8'h40);
        check("ovf_err",  32'(frame_err), 32'd1);
        check("ovf_code", 32'(err_code),  32'd2);
        drain(128, "ovf_drain");

        // Inter-byte timeout drops a partial frame.
        send_byte(8'hD5);
        send_byte(8'h04);
        send_byte(8'hAA);
        repeat (1999) @(negedge aclk);
        check("tmo_early", 32'(frame_err), 32'd0);
        @(negedge aclk);
        check("tmo_err",    32'(frame_err),     32'd1);
        check("tmo_code",   32'(err_code),      32'd4);
        check("tmo_hidden", 32'(m_axis.tvalid), 32'd0);

        // A byte on the expiry edge keeps the frame alive.
        send_byte(8'hD5);
        send_byte(8'h04);
        send_byte(8'hA1);
        repeat (1999) @(negedge aclk);
        send_byte(8'hB2);
        send_byte(8'hC3);
        send_byte(8'hD4);
`ifdef MANCH_DEFRAMER_CHK_EN
        send_byte(8'h04 ^ 8'hA1 ^ 8'hB2 ^ 8'hC3 ^ 8'hD4);
`endif
        check("alive_ok",   32'(frame_ok), 32'd1);
        check("alive_code", 32'(err_code), 32'd4);
        pl_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        expect_payload();
        drain(4, "alive");

        // Reset mid-payload discards a committed frame too.
        fill(3, 8'h60);
        send_frame(1'b0);
        check("mrst_pending", 32'(m_axis.tvalid), 32'd1);
        send_byte(8'hD5);
        send_byte(8'h05);
        send_byte(8'h01);
        send_byte(8'h02);
        areset = 1'b1;
        #1;
        check("mrst_tvalid", 32'(m_axis.tvalid), 32'd0);
        check("mrst_tdata",  32'(m_axis.tdata),  32'd0);
        check("mrst_code",   32'(err_code),      32'd0);
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        fill(5, 8'h70);
        expect_payload();
        send_frame(1'b0);
        check("post_rst_ok", 32'(frame_ok), 32'd1);
        drain(5, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
